// File: rtl/barrier_ctrl_multi.sv
// Multi-lane parking barrier controller with a shared lot occupancy counter.
// Entry lanes reserve a slot on grant; exit lanes release one on a vehicle pass.
module barrier_ctrl_multi #(
    parameter int unsigned N_LANES    = 2,
    parameter logic [7:0]  ENTRY_MASK = 8'b0000_0001,
    parameter int unsigned CAP        = 16,
    parameter int unsigned HOLD_CYC   = 8,
    parameter int unsigned TIMEOUT    = 32,
    localparam int unsigned CNT_W     = $clog2(CAP + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_LANES-1:0]     st,
    input  logic [2*N_LANES-1:0]   l,
    input  logic [N_LANES-1:0]     pass,
    output logic [N_LANES-1:0]     open,
    output logic [N_LANES-1:0]     rd_done,
    output logic [N_LANES-1:0]     reject,
    output logic [CNT_W-1:0]       occ,
    output logic                   full,
    output logic                   empty
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_OPEN = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam int unsigned TMR_MAX = (TIMEOUT > HOLD_CYC) ? TIMEOUT : HOLD_CYC;
    localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    // Extra headroom so up to eight same-cycle decrements cannot wrap the sum.
    localparam int unsigned SUM_W   = CNT_W + 5;

    logic [1:0]              state_q [N_LANES];
    logic [1:0]              state_d [N_LANES];
    logic [TMR_W-1:0]        tmr_q   [N_LANES];
    logic [TMR_W-1:0]        tmr_d   [N_LANES];
    logic [N_LANES-1:0]      open_d;
    logic [CNT_W-1:0]        occ_d;
    logic [SUM_W-1:0]        dec_cnt;
    logic signed [SUM_W-1:0] occ_sum;
    logic                    granted;

    assign full  = (occ == CNT_W'(CAP));
    assign empty = (occ == '0);

    // Per-lane next state, Mealy read responses, entry arbitration and occupancy update.
    always_comb begin
        granted = 1'b0;
        dec_cnt = '0;
        open_d  = '0;
        rd_done = '0;
        reject  = '0;
        for (int i = 0; i < N_LANES; i++) begin
            state_d[i] = state_q[i];
            tmr_d[i]   = tmr_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (reset && st[i]) begin
                        rd_done[i] = 1'b1;
                        if ((l[2*i +: 2] != 2'b11) || (ENTRY_MASK[i] && full)) begin
                            reject[i] = 1'b1;
                        end else begin
                            state_d[i] = S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (!ENTRY_MASK[i]) begin
                        state_d[i] = S_OPEN;
                        tmr_d[i]   = '0;
                    end else if (full) begin
                        reject[i]  = reset;
                        state_d[i] = S_IDLE;
                    end else if (!granted) begin
                        granted    = 1'b1;
                        state_d[i] = S_OPEN;
                        tmr_d[i]   = '0;
                    end
                end
                S_OPEN: begin
                    if (pass[i]) begin
                        state_d[i] = S_HOLD;
                        tmr_d[i]   = TMR_W'(HOLD_CYC - 1);
                        if (!ENTRY_MASK[i]) dec_cnt = dec_cnt + SUM_W'(1);
                    end else if (tmr_q[i] == TMR_W'(TIMEOUT - 1)) begin
                        state_d[i] = S_IDLE;
                        tmr_d[i]   = '0;
                        if (ENTRY_MASK[i]) dec_cnt = dec_cnt + SUM_W'(1);
                    end else begin
                        tmr_d[i] = tmr_q[i] + TMR_W'(1);
                    end
                end
                default: begin
                    if (tmr_q[i] == '0) begin
                        state_d[i] = S_IDLE;
                    end else begin
                        tmr_d[i] = tmr_q[i] - TMR_W'(1);
                    end
                end
            endcase
            open_d[i] = (state_d[i] == S_OPEN) || (state_d[i] == S_HOLD);
        end

        occ_sum = $signed(SUM_W'(occ)) + $signed(SUM_W'(granted)) - $signed(dec_cnt);
        if (occ_sum < 0) begin
            occ_d = '0;
        end else if (occ_sum > $signed(SUM_W'(CAP))) begin
            occ_d = CNT_W'(CAP);
        end else begin
            occ_d = CNT_W'(occ_sum);
        end
    end

    // State, timers, barrier outputs and occupancy registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_LANES; i++) begin
                state_q[i] <= S_IDLE;
                tmr_q[i]   <= '0;
            end
            open <= '0;
            occ  <= '0;
        end else begin
            for (int i = 0; i < N_LANES; i++) begin
                state_q[i] <= state_d[i];
                tmr_q[i]   <= tmr_d[i];
            end
            open <= open_d;
            occ  <= occ_d;
        end
    end

endmodule

// File: tb/tb_barrier_ctrl_multi.sv
// Directed bench for barrier_ctrl_multi: a default two-lane instance (entry + exit)
// and a three-entry-lane instance with CAP=2 for arbitration and full handling.
module tb_barrier_ctrl_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic [1:0] a_st, a_pass, a_open, a_rd, a_rej;
    logic [3:0] a_l;
    logic [4:0] a_occ;
    logic       a_full, a_empty;

    logic [2:0] b_st, b_pass, b_open, b_rd, b_rej;
    logic [5:0] b_l;
    logic [1:0] b_occ;
    logic       b_full, b_empty;

    barrier_ctrl_multi u_a (
        .clk(clk), .reset(reset), .st(a_st), .l(a_l), .pass(a_pass),
        .open(a_open), .rd_done(a_rd), .reject(a_rej), .occ(a_occ),
        .full(a_full), .empty(a_empty)
    );

    barrier_ctrl_multi #(
        .N_LANES(3), .ENTRY_MASK(8'b0000_0111), .CAP(2), .HOLD_CYC(8), .TIMEOUT(32)
    ) u_b (
        .clk(clk), .reset(reset), .st(b_st), .l(b_l), .pass(b_pass),
        .open(b_open), .rd_done(b_rd), .reject(b_rej), .occ(b_occ),
        .full(b_full), .empty(b_empty)
    );

    typedef struct {
        int         rep;
        logic       rst;
        logic [1:0] st;
        logic [3:0] l;
        logic [1:0] pass;
        logic [1:0] e_open;
        logic [1:0] e_rd;
        logic [1:0] e_rej;
        logic [4:0] e_occ;
    } vec_t;

    vec_t tbl[$];
    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(input int rep, input logic rst, input logic [1:0] st,
                                input logic [3:0] l, input logic [1:0] pass,
                                input logic [1:0] e_open, input logic [1:0] e_rd,
                                input logic [1:0] e_rej, input logic [4:0] e_occ);
        vec_t v;
        v.rep = rep; v.rst = rst; v.st = st; v.l = l; v.pass = pass;
        v.e_open = e_open; v.e_rd = e_rd; v.e_rej = e_rej; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Word layout: {open, rd_done, reject, occ, full, empty}
    task automatic a_drive(input logic [1:0] st, input logic [3:0] l, input logic [1:0] pass);
        @(negedge clk);
        a_st = st; a_l = l; a_pass = pass;
        #1;
    endtask

    task automatic a_chk(input string nm, input logic [1:0] e_open, input logic [1:0] e_rd,
                         input logic [1:0] e_rej, input logic [4:0] e_occ);
        cmp(nm, 32'({a_open, a_rd, a_rej, a_occ, a_full, a_empty}),
                32'({e_open, e_rd, e_rej, e_occ, (e_occ == 5'd16), (e_occ == 5'd0)}));
    endtask

    task automatic b_cyc(input string nm, input logic [2:0] st, input logic [5:0] l,
                         input logic [2:0] e_open, input logic [2:0] e_rd,
                         input logic [2:0] e_rej, input logic [1:0] e_occ);
        @(negedge clk);
        b_st = st; b_l = l; b_pass = 3'b000;
        #1;
        cmp(nm, 32'({b_open, b_rd, b_rej, b_occ, b_full, b_empty}),
                32'({e_open, e_rd, e_rej, e_occ, (e_occ == 2'd2), (e_occ == 2'd0)}));
    endtask

    initial begin
        reset = 1'b0;
        a_st = '0; a_l = '0; a_pass = '0;
        b_st = '0; b_l = '0; b_pass = '0;
        repeat (2) @(negedge clk);

        //           rep rst st     l        pass   open   rd     rej    occ
        tbl.push_back(mk(2,  0, 2'b01, 4'b0011, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0)); // reset gates rd_done
        tbl.push_back(mk(1,  1, 2'b01, 4'b0011, 2'b00, 2'b00, 2'b01, 2'b00, 5'd0)); // valid read
        tbl.push_back(mk(1,  1, 2'b01, 4'b0001, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0)); // REQ ignores st
        tbl.push_back(mk(1,  1, 2'b01, 4'b0011, 2'b01, 2'b01, 2'b00, 2'b00, 5'd1)); // OPEN, pass
        tbl.push_back(mk(7,  1, 2'b00, 4'b0000, 2'b01, 2'b01, 2'b00, 2'b00, 5'd1)); // HOLD ignores pass
        tbl.push_back(mk(1,  1, 2'b00, 4'b0000, 2'b00, 2'b01, 2'b00, 2'b00, 5'd1)); // last HOLD cycle
        tbl.push_back(mk(1,  1, 2'b01, 4'b0001, 2'b00, 2'b00, 2'b01, 2'b01, 5'd1)); // bad credential
        tbl.push_back(mk(1,  1, 2'b10, 4'b1100, 2'b00, 2'b00, 2'b10, 2'b00, 5'd1)); // exit read
        tbl.push_back(mk(1,  1, 2'b01, 4'b0011, 2'b00, 2'b00, 2'b01, 2'b00, 5'd1)); // entry read
        tbl.push_back(mk(1,  1, 2'b00, 4'b0000, 2'b10, 2'b10, 2'b00, 2'b00, 5'd1)); // grant + exit pass
        tbl.push_back(mk(1,  1, 2'b00, 4'b0000, 2'b01, 2'b11, 2'b00, 2'b00, 5'd1)); // occ unchanged
        tbl.push_back(mk(7,  1, 2'b00, 4'b0000, 2'b00, 2'b11, 2'b00, 2'b00, 5'd1));
        tbl.push_back(mk(1,  1, 2'b00, 4'b0000, 2'b00, 2'b01, 2'b00, 2'b00, 5'd1));
        tbl.push_back(mk(1,  1, 2'b10, 4'b1100, 2'b00, 2'b00, 2'b10, 2'b00, 5'd1));
        tbl.push_back(mk(1,  1, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 5'd1));
        tbl.push_back(mk(1,  1, 2'b00, 4'b0000, 2'b10, 2'b10, 2'b00, 2'b00, 5'd1)); // exit pass at 1
        tbl.push_back(mk(1,  1, 2'b00, 4'b0000, 2'b00, 2'b10, 2'b00, 2'b00, 5'd0));
        tbl.push_back(mk(7,  1, 2'b00, 4'b0000, 2'b00, 2'b10, 2'b00, 2'b00, 5'd0));
        tbl.push_back(mk(1,  1, 2'b10, 4'b1100, 2'b00, 2'b00, 2'b10, 2'b00, 5'd0));
        tbl.push_back(mk(1,  1, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0));
        tbl.push_back(mk(1,  1, 2'b00, 4'b0000, 2'b10, 2'b10, 2'b00, 2'b00, 5'd0)); // exit pass at 0
        tbl.push_back(mk(1,  1, 2'b00, 4'b0000, 2'b00, 2'b10, 2'b00, 2'b00, 5'd0)); // saturated
        tbl.push_back(mk(7,  1, 2'b00, 4'b0000, 2'b00, 2'b10, 2'b00, 2'b00, 5'd0));
        tbl.push_back(mk(1,  1, 2'b01, 4'b0011, 2'b00, 2'b00, 2'b01, 2'b00, 5'd0)); // entry for timeout
        tbl.push_back(mk(1,  1, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0));
        tbl.push_back(mk(32, 1, 2'b00, 4'b0000, 2'b00, 2'b01, 2'b00, 2'b00, 5'd1)); // 32 OPEN cycles
        tbl.push_back(mk(1,  1, 2'b00, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 5'd0)); // slot released

        foreach (tbl[k]) begin
            for (int r = 0; r < tbl[k].rep; r++) begin
                @(negedge clk);
                reset = tbl[k].rst;
                a_st = tbl[k].st; a_l = tbl[k].l; a_pass = tbl[k].pass;
                #1;
                a_chk($sformatf("vec%0d.%0d", k, r), tbl[k].e_open, tbl[k].e_rd,
                      tbl[k].e_rej, tbl[k].e_occ);
            end
        end

        // Three entry lanes contend with CAP=2.
        b_cyc("b_req3",     3'b111, 6'b111111, 3'b000, 3'b111, 3'b000, 2'd0);
        b_cyc("b_grant0",   3'b000, 6'b000000, 3'b000, 3'b000, 3'b000, 2'd0);
        b_cyc("b_grant1",   3'b000, 6'b000000, 3'b001, 3'b000, 3'b000, 2'd1);
        b_cyc("b_rej2",     3'b000, 6'b000000, 3'b011, 3'b000, 3'b100, 2'd2);
        b_cyc("b_full_rd",  3'b100, 6'b110000, 3'b011, 3'b100, 3'b100, 2'd2);
        b_cyc("b_steady",   3'b000, 6'b000000, 3'b011, 3'b000, 3'b000, 2'd2);

        // Fill to occ=5 with entry passes, then reset in HOLD.
        for (int k = 0; k < 5; k++) begin
            a_drive(2'b01, 4'b0011, 2'b00);
            a_drive(2'b00, 4'b0000, 2'b00);
            a_drive(2'b00, 4'b0000, 2'b01);
            a_chk($sformatf("fill%0d", k), 2'b01, 2'b00, 2'b00, 5'(k + 1));
            if (k < 4) repeat (8) a_drive(2'b00, 4'b0000, 2'b00);
        end
        a_drive(2'b00, 4'b0000, 2'b00);
        a_chk("hold_occ5", 2'b01, 2'b00, 2'b00, 5'd5);
        @(negedge clk);
        reset = 1'b0;
        a_drive(2'b00, 4'b0000, 2'b00);
        a_chk("reset_in_hold", 2'b00, 2'b00, 2'b00, 5'd0);
        reset = 1'b1;
        a_drive(2'b00, 4'b0000, 2'b00);
        a_chk("after_reset", 2'b00, 2'b00, 2'b00, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
